// File: rtl/scan_drv_pkg.sv
// scan_drv_pkg: shared FSM state encoding, MISR feedback polynomial and saturating counter helper.
package scan_drv_pkg;

    typedef enum logic [2:0] {IDLE, SHIFT, CAPTURE, WAIT, FLUSH, DONE} state_e;

    // x^3 + x + 1 in the low bits; wider chains use the low CHAIN_LEN bits
    localparam logic [31:0] MISR_POLY = 32'h0000_000B;

    function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic [31:0] max_v);
        return (v >= max_v) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/scan_drv_misr.sv
// scan_drv_misr: multiple-input signature register compacting observed scan-out bits.
module scan_drv_misr
    import scan_drv_pkg::*;
#(
    parameter int W = 3
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         clr_i,
    input  logic         en_i,
    input  logic         d_i,
    output logic [W-1:0] sig_o
);

    logic [W-1:0] sig_q;
    logic [W-1:0] poly;

    assign poly  = W'(MISR_POLY);
    assign sig_o = sig_q;

    // Galois-style step with the observed bit folded into bit 0
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)
            sig_q <= '0;
        else if (clr_i)
            sig_q <= '0;
        else if (en_i)
            sig_q <= (sig_q << 1) ^ (sig_q[W-1] ? poly : '0) ^ W'(d_i);
    end

endmodule

// File: rtl/scan_pattern_driver.sv
// scan_pattern_driver: streams scan patterns into one DUT chain and checks SO/PO responses.
// Define SCAN_DRV_MISR_EN to build the signature MISR; otherwise signature is tied to 0.
module scan_pattern_driver
    import scan_drv_pkg::*;
#(
    parameter int CHAIN_LEN = 3,
    parameter int PI_W      = 4,
    parameter int PO_W      = 1,
    parameter int CNT_W     = 8
) (
    input  logic                 CK,
    input  logic                 RSTN,
    input  logic                 pat_valid,
    output logic                 pat_ready,
    input  logic                 pat_last,
    input  logic [CHAIN_LEN-1:0] pat_si,
    input  logic [PI_W-1:0]      pat_pi,
    input  logic [PO_W-1:0]      pat_po,
    input  logic [CHAIN_LEN-1:0] pat_so,
    output logic                 dut_se,
    output logic                 dut_si,
    output logic [PI_W-1:0]      dut_pi,
    output logic                 dut_cke,
    input  logic                 dut_so,
    input  logic [PO_W-1:0]      dut_po,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic [CNT_W-1:0]     fail_cnt,
    output logic [CHAIN_LEN-1:0] signature
);

    localparam int KW = (CHAIN_LEN > 1) ? $clog2(CHAIN_LEN) : 1;
    localparam logic [KW-1:0] KLAST = KW'(CHAIN_LEN - 1);

    state_e               state_q;
    logic [KW-1:0]        k_q;
    logic [CHAIN_LEN-1:0] si_q;
    logic [CHAIN_LEN-1:0] so_q;
    logic [CHAIN_LEN-1:0] exp_so_q;
    logic [PI_W-1:0]      pi_q;
    logic [PO_W-1:0]      po_q;
    logic                 last_q;
    logic                 exp_vld_q;
    logic                 pass_q;
    logic [CNT_W-1:0]     fail_q;
    logic [CNT_W-1:0]     fail_d;
    logic [KW-1:0]        idx;
    logic                 shifting;
    logic                 so_cmp;
    logic                 mis;
    logic                 accept;
    logic                 k_end;

    // chain position addressed this cycle, MSB travels first
    assign idx      = KLAST - k_q;
    assign k_end    = (k_q == KLAST);
    assign shifting = (state_q == SHIFT) || (state_q == FLUSH);
    assign so_cmp   = ((state_q == SHIFT) && exp_vld_q) || (state_q == FLUSH);
    assign mis      = (so_cmp && (dut_so != exp_so_q[idx])) ||
                      ((state_q == CAPTURE) && (dut_po != po_q));
    assign fail_d   = mis ? CNT_W'(sat_inc(32'(fail_q), 32'({CNT_W{1'b1}}))) : fail_q;
    assign accept   = pat_valid && pat_ready;

    assign pat_ready = RSTN && ((state_q == IDLE) || (state_q == WAIT) ||
                                ((state_q == CAPTURE) && !last_q));
    assign dut_se    = shifting;
    assign dut_si    = (state_q == SHIFT) && si_q[idx];
    assign dut_cke   = shifting || (state_q == CAPTURE);
    assign dut_pi    = dut_cke ? pi_q : '0;
    assign busy      = (state_q != IDLE) && (state_q != DONE);
    assign done      = (state_q == DONE);
    assign pass      = pass_q;
    assign fail_cnt  = fail_q;

    // test sequencer: record intake, shift/capture/flush phases and mismatch accounting
    always_ff @(posedge CK or negedge RSTN) begin
        if (!RSTN) begin
            state_q   <= IDLE;
            k_q       <= '0;
            si_q      <= '0;
            so_q      <= '0;
            exp_so_q  <= '0;
            pi_q      <= '0;
            po_q      <= '0;
            last_q    <= 1'b0;
            exp_vld_q <= 1'b0;
            pass_q    <= 1'b0;
            fail_q    <= '0;
        end else begin
            if (accept)
                {si_q, pi_q, po_q, so_q, last_q} <= {pat_si, pat_pi, pat_po, pat_so, pat_last};
            case (state_q)
                IDLE: begin
                    k_q <= '0;
                    if (accept) begin
                        fail_q    <= '0;
                        exp_vld_q <= 1'b0;
                        pass_q    <= 1'b0;
                        state_q   <= SHIFT;
                    end
                end
                SHIFT: begin
                    fail_q <= fail_d;
                    k_q    <= k_end ? '0 : k_q + 1'b1;
                    if (k_end)
                        state_q <= CAPTURE;
                end
                CAPTURE: begin
                    fail_q    <= fail_d;
                    exp_so_q  <= so_q;
                    exp_vld_q <= 1'b1;
                    state_q   <= last_q ? FLUSH : (accept ? SHIFT : WAIT);
                end
                WAIT: begin
                    if (accept)
                        state_q <= SHIFT;
                end
                FLUSH: begin
                    fail_q <= fail_d;
                    k_q    <= k_end ? '0 : k_q + 1'b1;
                    if (k_end) begin
                        pass_q  <= (fail_d == '0);
                        state_q <= DONE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

`ifdef SCAN_DRV_MISR_EN
    scan_drv_misr #(.W(CHAIN_LEN)) u_misr (
        .clk_i  (CK),
        .rst_ni (RSTN),
        .clr_i  ((state_q == IDLE) && accept),
        .en_i   (so_cmp),
        .d_i    (dut_so),
        .sig_o  (signature)
    );
`else
    assign signature = '0;
`endif

endmodule

// File: tb/tb_scan_pattern_driver.sv
// tb_scan_pattern_driver: random pattern streams against an ideal 3-flop scan DUT model.
module tb_scan_pattern_driver;
    import scan_drv_pkg::*;

    logic       CK = 1'b0;
    logic       RSTN = 1'b0;
    logic       pat_valid = 1'b0;
    logic       pat_last = 1'b0;
    logic [2:0] pat_si = '0;
    logic [2:0] pat_so = '0;
    logic [3:0] pat_pi = '0;
    logic [0:0] pat_po = '0;
    logic       pat_ready, dut_se, dut_si, dut_cke, dut_so, busy, done, pass;
    logic [3:0] dut_pi;
    logic [0:0] dut_po;
    logic [7:0] fail_cnt;
    logic [2:0] signature;
    logic       s_ready, s_se, s_si, s_cke, s_busy, s_done, s_pass;
    logic [3:0] s_pi;
    logic [1:0] s_fail;
    logic [2:0] s_sig;
    logic [2:0] chain = '0;
    logic [21:0] outs;

    logic [2:0] r_si[8];
    logic [2:0] r_flip[8];
    logic [3:0] r_pi[8];
    logic       r_pflip[8];
    int         r_gap[8];
    int         errs = 0;
    int         checks = 0;

    scan_pattern_driver #(.CHAIN_LEN(3), .PI_W(4), .PO_W(1), .CNT_W(8)) dut (
        .CK(CK), .RSTN(RSTN), .pat_valid(pat_valid), .pat_ready(pat_ready), .pat_last(pat_last),
        .pat_si(pat_si), .pat_pi(pat_pi), .pat_po(pat_po), .pat_so(pat_so),
        .dut_se(dut_se), .dut_si(dut_si), .dut_pi(dut_pi), .dut_cke(dut_cke),
        .dut_so(dut_so), .dut_po(dut_po), .busy(busy), .done(done), .pass(pass),
        .fail_cnt(fail_cnt), .signature(signature)
    );

    scan_pattern_driver #(.CHAIN_LEN(3), .PI_W(4), .PO_W(1), .CNT_W(2)) dut_sat (
        .CK(CK), .RSTN(RSTN), .pat_valid(pat_valid), .pat_ready(s_ready), .pat_last(pat_last),
        .pat_si(pat_si), .pat_pi(pat_pi), .pat_po(pat_po), .pat_so(pat_so),
        .dut_se(s_se), .dut_si(s_si), .dut_pi(s_pi), .dut_cke(s_cke),
        .dut_so(dut_so), .dut_po(dut_po), .busy(s_busy), .done(s_done), .pass(s_pass),
        .fail_cnt(s_fail), .signature(s_sig)
    );

    // circuit under test: next-state and output logic of the benchmark
    function automatic logic [2:0] f(input logic [2:0] s, input logic [3:0] p);
        return {s[0] ^ p[0], (s[2] & p[1]) | p[3], s[1] ^ s[2] ^ p[2]};
    endfunction

    function automatic logic g(input logic [2:0] s, input logic [3:0] p);
        return s[2] ^ p[0] ^ (s[0] & p[3]);
    endfunction

    always #5 CK = ~CK;

    // ideal scan chain: chain[0] takes SI, chain[2] drives SO
    always @(posedge CK)
        if (dut_cke)
            chain <= dut_se ? {chain[1:0], dut_si} : f(chain, dut_pi);

    assign dut_so = chain[2];
    assign dut_po = g(chain, dut_pi);
    assign outs   = {pat_ready, dut_se, dut_si, dut_pi, dut_cke, busy, done, pass, fail_cnt, signature};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic set_rec(input int i, input logic [2:0] si, input logic [3:0] pi,
                           input logic [2:0] fl, input logic pf, input int gp);
        r_si[i] = si; r_pi[i] = pi; r_flip[i] = fl; r_pflip[i] = pf; r_gap[i] = gp;
    endtask

`ifdef SCAN_DRV_MISR_EN
    function automatic logic [2:0] misr_step(input logic [2:0] s, input logic b);
        logic [31:0] poly;
        poly = MISR_POLY;
        return {s[1:0], 1'b0} ^ (s[2] ? poly[2:0] : 3'b000) ^ {2'b00, b};
    endfunction
`endif

    task automatic run_test(input string name, input int n, input bit timed);
        logic [1:0] exp_q[$];
        logic [1:0] obs_q[$];
        int idx = 0, gap = 0, cyc = 0, t0 = -1, tdone = -1, extra = 0, exp_fail = 0;
`ifdef SCAN_DRV_MISR_EN
        logic [2:0] sig_m = '0;
        logic [2:0] tso;
`endif
        for (int i = 0; i < n; i++) begin
            for (int b = 2; b >= 0; b--) exp_q.push_back({1'b1, r_si[i][b]});
            exp_q.push_back(2'b00);
            exp_fail += $countones(r_flip[i]) + int'(r_pflip[i]);
`ifdef SCAN_DRV_MISR_EN
            tso = f(r_si[i], r_pi[i]);
            for (int b = 2; b >= 0; b--) sig_m = misr_step(sig_m, tso[b]);
`endif
        end
        for (int b = 0; b < 3; b++) exp_q.push_back(2'b10);
        while (tdone < 0 && cyc < 200) begin
            if (idx < n && gap == 0) begin
                pat_valid = 1'b1;
                pat_si    = r_si[idx];
                pat_pi    = r_pi[idx];
                pat_so    = f(r_si[idx], r_pi[idx]) ^ r_flip[idx];
                pat_po    = g(r_si[idx], r_pi[idx]) ^ r_pflip[idx];
                pat_last  = (idx == n - 1);
            end else if (idx >= n) begin
                pat_valid = 1'b1;
                pat_last  = 1'b0;
                pat_si    = 3'($urandom);
                pat_pi    = 4'($urandom);
            end else
                pat_valid = 1'b0;
            @(negedge CK);
            if (dut_cke) obs_q.push_back(dut_se ? {1'b1, dut_si} : 2'b00);
            if (pat_valid && pat_ready) begin
                if (idx < n) begin
                    if (idx == 0) t0 = cyc;
                    idx++;
                    gap = (idx < n) ? r_gap[idx] : 0;
                end else
                    extra++;
            end else if (!pat_valid && gap > 0)
                gap--;
            if (done) begin
                tdone = cyc;
                chk({name, " fail_cnt"}, 32'(fail_cnt), (exp_fail > 255) ? 255 : exp_fail);
                chk({name, " sat fail_cnt"}, 32'(s_fail), (exp_fail > 3) ? 3 : exp_fail);
                chk({name, " pass"}, 32'(pass), 32'(exp_fail == 0));
                chk({name, " busy at done"}, 32'(busy), 0);
`ifdef SCAN_DRV_MISR_EN
                chk({name, " signature"}, 32'(signature), 32'(sig_m));
`else
                chk({name, " signature"}, 32'(signature), 0);
`endif
            end
            @(posedge CK); #1;
            cyc++;
        end
        pat_valid = 1'b0;
        chk({name, " done seen"}, 32'(tdone >= 0), 1);
        if (timed) chk({name, " latency"}, tdone - t0, 4 * n + 4);
        chk({name, " extra accepts"}, extra, 0);
        chk({name, " cke cycles"}, obs_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++)
            chk($sformatf("%s stream[%0d]", name, i),
                (i < obs_q.size()) ? 32'(obs_q[i]) : 32'hdead, 32'(exp_q[i]));
        repeat (2) @(posedge CK);
        #1;
        chk({name, " fail_cnt hold"}, 32'(fail_cnt), (exp_fail > 255) ? 255 : exp_fail);
    endtask

    initial begin
        int n, w;
        bit stall;
        repeat (2) @(posedge CK);
        @(negedge CK);
        chk("reset outputs", 32'(outs), 0);
        RSTN = 1'b1;
        @(posedge CK); #1;

        set_rec(0, 3'b101, 4'($urandom), 3'b000, 1'b0, 0);
        run_test("single", 1, 1);

        for (int i = 0; i < 2; i++) set_rec(i, 3'($urandom), 4'($urandom), 3'b000, 1'b0, 0);
        run_test("pair", 2, 1);

        set_rec(0, 3'($urandom), 4'($urandom), 3'b010, 1'b0, 0);
        run_test("so flip", 1, 1);

        set_rec(0, 3'($urandom), 4'($urandom), 3'b000, 1'b1, 0);
        run_test("po flip", 1, 1);

        set_rec(0, 3'($urandom), 4'($urandom), 3'b000, 1'b0, 0);
        set_rec(1, 3'($urandom), 4'($urandom), 3'b000, 1'b0, 8);
        set_rec(2, 3'($urandom), 4'($urandom), 3'b000, 1'b0, 6);
        run_test("stall", 3, 0);

        pat_si = 3'b110; pat_pi = 4'hA; pat_last = 1'b0; pat_valid = 1'b1;
        w = 0;
        while (!(pat_valid && pat_ready) && w < 10) begin
            @(negedge CK);
            if (!(pat_valid && pat_ready)) begin @(posedge CK); #1; end
            w++;
        end
        chk("abort accept", 32'(w < 10), 1);
        @(posedge CK); #1;
        pat_valid = 1'b0;
        @(posedge CK); #2;
        chk("abort busy before", 32'(busy), 1);
        RSTN = 1'b0;
        #1;
        chk("abort outputs", 32'(outs), 0);
        repeat (2) begin
            @(negedge CK);
            chk("abort held", 32'(outs), 0);
        end
        RSTN = 1'b1;
        @(posedge CK); #1;
        for (int i = 0; i < 2; i++) set_rec(i, 3'($urandom), 4'($urandom), 3'b000, 1'b0, 0);
        run_test("after abort", 2, 1);

        set_rec(0, 3'($urandom), 4'($urandom), 3'b111, 1'b0, 0);
        set_rec(1, 3'($urandom), 4'($urandom), 3'b011, 1'b0, 0);
        run_test("saturate", 2, 1);

        for (int t = 0; t < 10; t++) begin
            n = $urandom_range(1, 6);
            stall = ($urandom_range(0, 1) == 1);
            for (int i = 0; i < n; i++)
                set_rec(i, 3'($urandom), 4'($urandom),
                        ($urandom_range(0, 3) == 0) ? 3'($urandom) : 3'b000,
                        ($urandom_range(0, 4) == 0),
                        stall ? $urandom_range(0, 5) : 0);
            run_test($sformatf("rand%0d", t), n, !stall);
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
